// File: rtl/stack_unit.sv
// stack_unit: PUSH/POP/CALL/RET sequencer with one memory transfer and one write-back cycle
module stack_unit (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_data,
  input  logic [31:0] ret_addr,
  input  logic [2:0]  dst_reg,
  input  logic [31:0] resp,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        we,
  output logic [2:0]  wa,
  output logic [31:0] wd,
  output logic        wespen,
  output logic [31:0] wespd,
  output logic        pc_we,
  output logic [31:0] pc_wd
);
  typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
  state_t state, nxt;
  logic [1:0]  op_l;
  logic [2:0]  dst_l;
  logic [31:0] sp_l, wdat_l, rd_l;
  logic        in_req, in_wb, wr, pop, esp_pop;
  logic [31:0] new_sp;
  // state register
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= nxt;
  // operand capture at start, read data capture at ack
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      op_l   <= '0;
      dst_l  <= '0;
      sp_l   <= '0;
      wdat_l <= '0;
      rd_l   <= '0;
    end else begin
      if (state == IDLE && start) begin
        op_l   <= op;
        dst_l  <= dst_reg;
        sp_l   <= resp;
        wdat_l <= op[1] ? ret_addr : src_data;
      end
      if (state == REQ && mem_ack) rd_l <= mem_rdata;
    end
  // next-state: single handshake then one write-back cycle
  always_comb
    nxt = state == IDLE ? (start ? REQ : IDLE) :
          state == REQ  ? (mem_ack ? WB : REQ) : IDLE;
  // outputs decoded from state and latched operands only
  always_comb begin
    in_req    = state == REQ;
    in_wb     = state == WB;
    wr        = ~op_l[0];
    pop       = op_l == 2'b01;
    esp_pop   = pop && dst_l == 3'b100;
    new_sp    = wr ? sp_l - 32'd4 : sp_l + 32'd4;
    mem_req   = in_req;
    mem_we    = in_req & wr;
    mem_addr  = in_req ? (wr ? sp_l - 32'd4 : sp_l) : '0;
    mem_wdata = (in_req & wr) ? wdat_l : '0;
    busy      = state != IDLE;
    done      = in_wb;
    wespen    = in_wb;
    wespd     = in_wb ? (esp_pop ? rd_l : new_sp) : '0;
    we        = in_wb & pop & ~esp_pop;
    wa        = we ? dst_l : '0;
    wd        = we ? rd_l : '0;
    pc_we     = in_wb & (op_l == 2'b11);
    pc_wd     = pc_we ? rd_l : '0;
  end
endmodule

// File: doc/stack_unit.md
# stack_unit

Multi-cycle PUSH/POP/CALL/RET sequencer that sits directly upstream of the register file. It reads the current stack pointer (`resp`) and performs one 32-bit memory transfer through a req/ack handshake. It then issues a single write-back cycle that drives the register file's general write port (`we`/`wa`/`wd`), its dedicated stack-pointer port (`wespen`/`wespd`) and the PC load port.

## Interface
- No parameters; data width fixed at 32, register address width fixed at 3, stack slot = 4 bytes.
- `clk` in 1: single clock, all state on rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin operation; sampled only in IDLE.
- `op` in 2: 00 PUSH, 01 POP, 10 CALL, 11 RET.
- `src_data` in 32: value pushed by PUSH.
- `ret_addr` in 32: return address pushed by CALL.
- `dst_reg` in 3: POP destination register index.
- `resp` in 32: current ESP from register file.
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: 1 = write (PUSH/CALL), 0 = read (POP/RET).
- `mem_addr` out 32: byte address.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `mem_ack` in 1: transfer complete.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse in WB.
- `we`, `wa[2:0]`, `wd[31:0]` out: general register write port.
- `wespen`, `wespd[31:0]` out: ESP write port.
- `pc_we`, `pc_wd[31:0]` out: PC load for RET.

## Operation
- States: IDLE, REQ, WB. All outputs are registered or decoded from state plus latched values. No combinational path runs from `start` or `mem_ack` to any output.
- IDLE -> REQ when `start`=1. On that edge, latch:
  - `op` and `dst_reg`;
  - `sp_l` = `resp`;
  - `wdat_l` = `src_data` (PUSH) or `ret_addr` (CALL).
- Address rule, modulo 2^32 with no alignment check:
  - PUSH/CALL: `mem_addr` = `sp_l` − 4.
  - POP/RET: `mem_addr` = `sp_l`.
- Write-back ESP value:
  - PUSH/CALL: `new_sp` = `sp_l` − 4.
  - POP/RET: `new_sp` = `sp_l` + 4.
  - Wrap is silent: 0x00000000 − 4 = 0xFFFFFFFC; 0xFFFFFFFC + 4 = 0x00000000.
- REQ:
  - `mem_req`=1; `mem_we`, `mem_addr` and `mem_wdata` are stable for the whole state.
  - On `mem_ack`=1, latch `mem_rdata` into `rd_l` and go to WB. Otherwise stay.
- WB (exactly one cycle), then -> IDLE:
  - `done`=1 and `wespen`=1.
  - PUSH/CALL: `wespd` = `new_sp`; `we`=0; `pc_we`=0.
  - POP with `dst_reg` != 3'b100: `we`=1, `wa`=`dst_reg`, `wd`=`rd_l`, `wespd`=`new_sp`.
  - POP with `dst_reg` == 3'b100: `we`=0, `wespd`=`rd_l`. The popped value wins over the increment.
  - RET: `pc_we`=1, `pc_wd`=`rd_l`, `wespd`=`new_sp`.
- PUSH ESP pushes the old ESP value, because `src_data` is latched at start.
- `start` while busy is ignored; no queueing.
- `mem_ack` outside REQ is ignored.
- `op`, `src_data` and `resp` changes after the start edge have no effect.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State = IDLE.
  - Outputs zero: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `we`, `wa`, `wd`, `wespen`, `wespd`, `pc_we`, `pc_wd`.
  - Latches cleared.
- Reset mid-operation: `mem_req` drops immediately. No write-back issues and no `done` pulse.
- Latency for a start edge at cycle 0 with ack first seen at cycle k ≥ 1:
  - Cycle 1: `mem_req` rises.
  - Cycle k: ack sampled.
  - Cycle k+1: WB (`done` and the register writes).
  - Cycle k+2: IDLE; a new `start` is accepted at the end of this cycle.
- Minimum period with zero-wait ack (ack at cycle 1) is 3 cycles start-to-start.
- `busy` is high from cycle 1 through the WB cycle inclusive.
- All write strobes (`we`, `wespen`, `pc_we`) are high for exactly one cycle per operation and never outside WB.

## Test plan
- Reset then PUSH:
  - Stimulus: `resp`=0x00001000, `src_data`=0xDEADBEEF, ack after 2 wait cycles.
  - Required: `mem_addr`=0x00000FFC, `mem_we`=1, `mem_wdata`=0xDEADBEEF held 3 cycles; WB `wespd`=0x00000FFC, `we`=0, `done` one cycle.
- POP to ebx:
  - Stimulus: `resp`=0x00000FFC, `dst_reg`=3, `mem_rdata`=0x12345678, zero-wait ack.
  - Required: `mem_addr`=0x00000FFC, `mem_we`=0; WB `we`=1, `wa`=3, `wd`=0x12345678, `wespd`=0x00001000; `done` 2 cycles after start.
- POP esp:
  - Stimulus: `dst_reg`=4, `mem_rdata`=0x00002000.
  - Required: WB `we`=0, `wespen`=1, `wespd`=0x00002000.
- CALL/RET and wrap:
  - CALL with `resp`=0, `ret_addr`=0x40: `mem_addr`=0xFFFFFFFC, WB `wespd`=0xFFFFFFFC.
  - Then RET with `resp`=0xFFFFFFFC, rdata=0x40: `pc_we`=1, `pc_wd`=0x40, `wespd`=0x00000000.
- Start while busy plus stray ack:
  - Stimulus: `start` pulses during REQ and WB; `mem_ack` pulses in IDLE.
  - Required: exactly one `done` per accepted start; no extra `mem_req`.
- Reset mid-REQ:
  - Stimulus: assert `n_rst`=0 while `mem_req`=1.
  - Required: `mem_req`=0 immediately, no WB strobes; the next PUSH after release behaves as in the first scenario.
